// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI command/register controller of the MIDI router:
// register map, STATUS bit positions, command format and FSM encoding.
package spi_reg_pkg;

  localparam logic [6:0] ADDR_ID         = 7'h00;
  localparam logic [6:0] ADDR_CTRL       = 7'h01;
  localparam logic [6:0] ADDR_STATUS     = 7'h02;
  localparam logic [6:0] ADDR_ROUTE_BASE = 7'h10;

  localparam int STAT_ERR = 0;
  localparam int STAT_TMO = 1;
  localparam int STAT_OVR = 2;
  localparam int STAT_W   = 3;

  localparam int CMD_RD_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_DATA = 2'd1,
    ST_RD_DATA = 2'd2
  } state_t;

  // True when the 7-bit address hits a register that exists for this port count.
  function automatic logic addr_valid(input logic [6:0] addr, input int n_ports);
    int route_off;
    route_off = int'(addr) - int'(ADDR_ROUTE_BASE);
    return (addr == ADDR_ID) || (addr == ADDR_CTRL) || (addr == ADDR_STATUS) ||
           ((route_off >= 0) && (route_off < n_ports));
  endfunction

endpackage

// File: rtl/spi_reg_timeout.sv
// Inter-frame watchdog: counts clk cycles while enabled, saturates at TIMEOUT-1
// and flags the terminal count.
module spi_reg_timeout
  import spi_reg_pkg::*;
#(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int               CNT_W  = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !tc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/spi_reg_ctrl.sv
// Command/register controller behind the SPI slave byte engine: decodes
// command+data frames, holds CTRL/ROUTE configuration and a sticky STATUS with irq.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int         N_PORTS = 4,
  parameter int         TIMEOUT = 65535,
  parameter logic [7:0] DEV_ID  = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_byte,
  input  logic                 rx_rdy,
  output logic [7:0]           tx_byte,
  output logic                 tx_ld,
  output logic [7:0]           ctrl,
  output logic [8*N_PORTS-1:0] route,
  output logic                 irq
);

  state_t             state_q, state_nxt;
  logic [6:0]         rx_addr, wr_addr_q;
  logic [7:0]         ctrl_q, tx_byte_q, rd_data;
  logic [N_PORTS-1:0] route_q [N_PORTS];
  logic [STAT_W-1:0]  status_q, status_set, status_clr;
  logic               tx_ld_q, irq_q;
  logic               rd_ok, wr_ok;
  logic               cmd_rd, cmd_wr, commit, tmo_hit;
  logic               tmo_clr, tmo_en, tmo_tc;

  assign rx_addr = rx_byte[6:0];
  assign rd_ok   = addr_valid(rx_addr, N_PORTS);
  assign wr_ok   = addr_valid(wr_addr_q, N_PORTS);

  // Watchdog only runs while a transaction is half-done; every frame restarts it.
  assign tmo_clr = rx_rdy || (state_q == ST_IDLE);
  assign tmo_en  = (state_q != ST_IDLE);

  spi_reg_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tmo_clr),
    .en   (tmo_en),
    .tc   (tmo_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // A frame always takes priority over a timeout landing in the same cycle.
  always_comb begin
    state_nxt = state_q;
    cmd_rd    = 1'b0;
    cmd_wr    = 1'b0;
    commit    = 1'b0;
    tmo_hit   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_rdy) begin
          if (rx_byte[CMD_RD_BIT]) begin
            cmd_rd    = 1'b1;
            state_nxt = ST_RD_DATA;
          end else begin
            cmd_wr    = 1'b1;
            state_nxt = ST_WR_DATA;
          end
        end
      end
      ST_WR_DATA: begin
        if (rx_rdy) begin
          commit    = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tmo_tc) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_RD_DATA: begin
        if (rx_rdy) begin
          state_nxt = ST_IDLE;
        end else if (tmo_tc) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_data = 8'h00;
    if (rx_addr == ADDR_ID) begin
      rd_data = DEV_ID;
    end else if (rx_addr == ADDR_CTRL) begin
      rd_data = ctrl_q;
    end else if (rx_addr == ADDR_STATUS) begin
      rd_data = 8'(status_q);
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (rx_addr == ADDR_ROUTE_BASE + 7'(i)) rd_data = 8'(route_q[i]);
      end
    end
  end

  // Sets are OR-ed in after the write-1-to-clear mask so a same-cycle event is kept.
  always_comb begin
    status_set = '0;
    status_clr = '0;
    if ((cmd_rd && !rd_ok) || (commit && !wr_ok)) status_set[STAT_ERR] = 1'b1;
    if (tmo_hit)                                  status_set[STAT_TMO] = 1'b1;
    if (rx_rdy && tx_ld_q)                        status_set[STAT_OVR] = 1'b1;
    if (commit && (wr_addr_q == ADDR_STATUS))     status_clr = rx_byte[STAT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q <= '0;
      ctrl_q    <= '0;
      tx_byte_q <= '0;
      tx_ld_q   <= 1'b0;
      status_q  <= '0;
      irq_q     <= 1'b0;
      for (int i = 0; i < N_PORTS; i++) route_q[i] <= '0;
    end else begin
      tx_ld_q  <= cmd_rd;
      status_q <= (status_q & ~status_clr) | status_set;
      irq_q    <= (|status_q) && ctrl_q[7];
      if (cmd_rd) tx_byte_q <= rd_data;
      if (cmd_wr) wr_addr_q <= rx_addr;
      if (commit && (wr_addr_q == ADDR_CTRL)) ctrl_q <= rx_byte;
      for (int i = 0; i < N_PORTS; i++) begin
        if (commit && (wr_addr_q == ADDR_ROUTE_BASE + 7'(i))) route_q[i] <= rx_byte[N_PORTS-1:0];
      end
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_route
    assign route[8*g +: 8] = 8'(route_q[g]);
  end

  assign tx_byte = tx_byte_q;
  assign tx_ld   = tx_ld_q;
  assign ctrl    = ctrl_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: transaction-level reference model compared
// every cycle, plus directed frame sequences with hand-computed expectations.
module tb_spi_reg_ctrl;

  localparam int NP  = 4;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    rx_byte;
  logic          rx_rdy;
  logic [7:0]    tx_byte;
  logic          tx_ld;
  logic [7:0]    ctrl;
  logic [8*NP-1:0] route;
  logic          irq;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  spi_reg_ctrl #(
    .N_PORTS(NP),
    .TIMEOUT(TMO),
    .DEV_ID (8'hA5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_byte(rx_byte),
    .rx_rdy (rx_rdy),
    .tx_byte(tx_byte),
    .tx_ld  (tx_ld),
    .ctrl   (ctrl),
    .route  (route),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is either absent, an awaited write, or an awaited dummy.
  logic [7:0]  m_ctrl, m_tx_byte, n_ctrl, n_tx_byte;
  logic [3:0]  m_route [NP];
  logic [3:0]  n_route [NP];
  logic [2:0]  m_status, n_status, s_set, s_clr;
  logic        m_irq, m_tx_ld, n_tx_ld;
  logic [1:0]  m_pend, n_pend;
  logic [6:0]  m_waddr, n_waddr;
  int          m_age, n_age;
  logic [8:0]  rd_res;
  logic [31:0] m_route_vec;
  int          woff;

  function automatic logic [8:0] model_read(input logic [6:0] a);
    int off;
    off = int'(a) - 16;
    if (a == 7'h00) return {1'b1, 8'hA5};
    if (a == 7'h01) return {1'b1, m_ctrl};
    if (a == 7'h02) return {1'b1, 5'b0, m_status};
    if (off >= 0 && off < NP) return {1'b1, 4'b0, m_route[off[1:0]]};
    return 9'h000;
  endfunction

  always_comb begin
    n_ctrl    = m_ctrl;
    n_route   = m_route;
    n_tx_byte = m_tx_byte;
    n_tx_ld   = 1'b0;
    n_pend    = m_pend;
    n_waddr   = m_waddr;
    n_age     = m_age;
    s_set     = 3'b000;
    s_clr     = 3'b000;
    rd_res    = 9'h000;
    woff      = int'(m_waddr) - 16;
    if (rx_rdy) begin
      n_age = 0;
      if (m_tx_ld) s_set[2] = 1'b1;
      if (m_pend == 2'd0) begin
        if (rx_byte[7]) begin
          rd_res    = model_read(rx_byte[6:0]);
          n_tx_ld   = 1'b1;
          n_tx_byte = rd_res[7:0];
          if (!rd_res[8]) s_set[0] = 1'b1;
          n_pend = 2'd2;
        end else begin
          n_pend  = 2'd1;
          n_waddr = rx_byte[6:0];
        end
      end else if (m_pend == 2'd1) begin
        n_pend = 2'd0;
        if (m_waddr == 7'h01) n_ctrl = rx_byte;
        else if (m_waddr == 7'h02) s_clr = rx_byte[2:0];
        else if (woff >= 0 && woff < NP) n_route[woff[1:0]] = rx_byte[3:0];
        else if (m_waddr != 7'h00) s_set[0] = 1'b1;
      end else begin
        n_pend = 2'd0;
      end
    end else if (m_pend != 2'd0) begin
      n_age = m_age + 1;
      if (n_age == TMO) begin
        n_pend   = 2'd0;
        s_set[1] = 1'b1;
      end
    end
    n_status = (m_status & ~s_clr) | s_set;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ctrl    <= 8'h00;
      m_route   <= '{default: 4'h0};
      m_status  <= 3'b000;
      m_irq     <= 1'b0;
      m_tx_ld   <= 1'b0;
      m_tx_byte <= 8'h00;
      m_pend    <= 2'd0;
      m_waddr   <= 7'h00;
      m_age     <= 0;
    end else begin
      m_ctrl    <= n_ctrl;
      m_route   <= n_route;
      m_status  <= n_status;
      m_irq     <= (|m_status) && m_ctrl[7];
      m_tx_ld   <= n_tx_ld;
      m_tx_byte <= n_tx_byte;
      m_pend    <= n_pend;
      m_waddr   <= n_waddr;
      m_age     <= n_age;
    end
  end

  assign m_route_vec = {4'h0, m_route[3], 4'h0, m_route[2], 4'h0, m_route[1], 4'h0, m_route[0]};

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_ctrl",    32'(ctrl),    32'(m_ctrl));
      chk("model_route",   32'(route),   m_route_vec);
      chk("model_irq",     32'(irq),     32'(m_irq));
      chk("model_tx_ld",   32'(tx_ld),   32'(m_tx_ld));
      chk("model_tx_byte", 32'(tx_byte), 32'(m_tx_byte));
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_byte = b;
    rx_rdy  = 1'b1;
    @(negedge clk);
    rx_rdy  = 1'b0;
  endtask

  task automatic wr_reg(input logic [6:0] a, input logic [7:0] d);
    send({1'b0, a});
    send(d);
  endtask

  task automatic rd_reg(input string name, input logic [6:0] a, input logic [7:0] exp);
    send({1'b1, a});
    chk({name, "_ld"},   32'(tx_ld),   32'd1);
    chk({name, "_data"}, 32'(tx_byte), 32'(exp));
    @(negedge clk);
    chk({name, "_ld_off"}, 32'(tx_ld), 32'd0);
    send(8'h00);
  endtask

  initial begin
    rst_n   = 1'b0;
    rx_byte = 8'h00;
    rx_rdy  = 1'b0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_tx_byte", 32'(tx_byte), 32'h0);
    chk("rst_tx_ld",   32'(tx_ld),   32'h0);
    chk("rst_ctrl",    32'(ctrl),    32'h0);
    chk("rst_route",   32'(route),   32'h0);
    chk("rst_irq",     32'(irq),     32'h0);
    #2 rst_n = 1'b1;

    // Reads of reset values and the device ID
    rd_reg("rd_ctrl_rst", 7'h01, 8'h00);
    rd_reg("rd_id", 7'h00, 8'hA5);
    rd_reg("rd_status_rst", 7'h02, 8'h00);

    // Route writes, masking to N_PORTS bits, readback
    wr_reg(7'h11, 8'h0B);
    chk("route1", 32'(route[15:8]), 32'h0B);
    rd_reg("rd_route1", 7'h11, 8'h0B);
    wr_reg(7'h10, 8'hFF);
    chk("route0_mask", 32'(route[7:0]), 32'h0F);
    rd_reg("rd_route0", 7'h10, 8'h0F);

    // Invalid write address with irq enabled, then W1C
    wr_reg(7'h01, 8'h80);
    chk("ctrl_irqen", 32'(ctrl), 32'h80);
    wr_reg(7'h7F, 8'h55);
    chk("inv_ctrl", 32'(ctrl), 32'h80);
    chk("inv_route", 32'(route), 32'h0000_0B0F);
    chk("inv_irq_early", 32'(irq), 32'h0);
    @(negedge clk);
    chk("inv_irq", 32'(irq), 32'h1);
    rd_reg("rd_status_err", 7'h02, 8'h01);
    wr_reg(7'h02, 8'h01);
    @(negedge clk);
    chk("w1c_irq", 32'(irq), 32'h0);
    rd_reg("rd_status_clr", 7'h02, 8'h00);

    // Data arriving well inside the window is still committed
    send(8'h01);
    repeat (10) @(negedge clk);
    send(8'h81);
    chk("slow_commit", 32'(ctrl), 32'h81);
    wr_reg(7'h01, 8'h80);

    // Timeout: abandoned write, next byte is a fresh command
    send(8'h01);
    repeat (20) @(negedge clk);
    chk("tmo_irq", 32'(irq), 32'h1);
    send(8'h42);
    chk("tmo_no_commit", 32'(ctrl), 32'h80);
    send(8'h00);
    rd_reg("rd_status_tmo", 7'h02, 8'h03);
    wr_reg(7'h02, 8'h03);

    // Reset in the middle of a write
    send(8'h01);
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    chk("midrst_ctrl", 32'(ctrl), 32'h0);
    rd_reg("rd_after_rst", 7'h7F, 8'h00);
    chk("midrst_ctrl2", 32'(ctrl), 32'h0);
    wr_reg(7'h02, 8'h07);
    rd_reg("rd_status_clr2", 7'h02, 8'h00);

    // Frame landing on the tx_ld cycle
    @(negedge clk);
    rx_byte = 8'h81;
    rx_rdy  = 1'b1;
    @(negedge clk);
    rx_byte = 8'h00;
    chk("ovr_tx_ld", 32'(tx_ld), 32'h1);
    @(negedge clk);
    rx_rdy = 1'b0;
    rd_reg("rd_status_ovr", 7'h02, 8'h04);

    // Back-to-back command and data
    @(negedge clk);
    rx_byte = 8'h12;
    rx_rdy  = 1'b1;
    @(negedge clk);
    rx_byte = 8'h05;
    @(negedge clk);
    rx_rdy = 1'b0;
    chk("b2b_route2", 32'(route[23:16]), 32'h05);

    // Invalid read address
    rd_reg("rd_invalid", 7'h20, 8'h00);
    rd_reg("rd_status_err2", 7'h02, 8'h05);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
